load_store_unit: RTL and testbench

- Back end of the decoder's memory controls: consumes MemWrite, MemtoReg, ByteControl and Arith_u, plus the ALU address and rt store data.
- Runs a single-outstanding req/ack transaction on the word-wide data-memory port and stalls the pipeline until the transaction completes.
- Generates byte enables and replicated store data; extracts and sign/zero-extends load data.
- Flags misaligned accesses and memory timeouts toward the coprocessor.

---
 rtl/load_store_unit_if.sv | 28 ++
 rtl/load_store_unit.sv | 227 ++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Data-memory port between the load/store unit (master) and memory (slave).
// Word-wide, single-outstanding req/ack handshake:
//   mem_req   master->slave  transaction request, held until mem_ack
//   mem_we    master->slave  1 = write
//   mem_be    master->slave  byte enables, bit i = byte lane i
//   mem_addr  master->slave  word-aligned address
//   mem_wdata master->slave  lane-replicated store data
//   mem_rdata slave->master  read word, valid with mem_ack
//   mem_ack   slave->master  one-cycle completion strobe
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns decoder memory controls into one req/ack
// transaction on the data-memory port, stalling the pipeline meanwhile.
// Ports:
//   clk, rst              clock, async active-high reset
//   MemWrite, MemtoReg    store / load request (both high = store)
//   ByteControl           1111 word, 0011 half, 0001 byte, other = no access
//   Arith_u               1 = zero-extend load, 0 = sign-extend
//   alu_result            effective byte address
//   store_data            rt value for stores
//   mem                   data-memory port (master side)
//   stall                 combinational pipeline hold
//   load_valid, load_data extended load result, load_data held between loads
//   addr_err, bus_err     one-cycle misalignment / timeout pulses
//   badvaddr              faulting byte address, held until the next error
module load_store_unit #(
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      MemWrite,
  input  logic                      MemtoReg,
  input  logic [3:0]                ByteControl,
  input  logic                      Arith_u,
  input  logic [31:0]               alu_result,
  input  logic [31:0]               store_data,
  load_store_unit_if.master         mem,
  output logic                      stall,
  output logic                      load_valid,
  output logic [31:0]               load_data,
  output logic                      addr_err,
  output logic                      bus_err,
  output logic [31:0]               badvaddr
);

  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_DONE  = 3'd2,
    ST_ERR_A = 3'd3,
    ST_ERR_B = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]   mem_addr_q, mem_addr_d;
  logic [BW-1:0]   mem_be_q, mem_be_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            mem_we_q, mem_we_d;
  logic            mem_req_q, mem_req_d;
  logic [1:0]      lane_q, lane_d;
  size_e           size_q, size_d;
  logic            unsigned_q, unsigned_d;
  logic            load_valid_q, load_valid_d;
  logic [DW-1:0]   load_data_q, load_data_d;
  logic            addr_err_q, addr_err_d;
  logic            bus_err_q, bus_err_d;
  logic [DW-1:0]   badvaddr_q, badvaddr_d;

  logic            is_word_c, is_half_c, is_byte_c;
  logic            acc_c, aligned_c;
  logic [BW-1:0]   be_c;
  logic [DW-1:0]   wdata_c;
  logic [DW-1:0]   lane_word_c;
  logic [DW-1:0]   ext_c;

  // Decode the incoming request: access size, alignment, lanes, store data.
  always_comb begin
    is_word_c = (ByteControl == 4'b1111);
    is_half_c = (ByteControl == 4'b0011);
    is_byte_c = (ByteControl == 4'b0001);
    acc_c     = (MemWrite | MemtoReg) & (is_word_c | is_half_c | is_byte_c);

    aligned_c = 1'b1;
    be_c      = 4'b1111;
    wdata_c   = store_data;
    if (is_word_c) begin
      aligned_c = (alu_result[1:0] == 2'b00);
    end else if (is_half_c) begin
      aligned_c = ~alu_result[0];
      be_c      = BW'(4'b0011 << {alu_result[1], 1'b0});
      wdata_c   = {2{store_data[15:0]}};
    end else begin
      be_c      = BW'(4'b0001 << alu_result[1:0]);
      wdata_c   = {4{store_data[7:0]}};
    end
  end

  // Pick the addressed lane out of the read word and extend it.
  always_comb begin
    lane_word_c = mem.mem_rdata >> {lane_q, 3'b000};
    case (size_q)
      SZ_BYTE: ext_c = unsigned_q ? {24'b0, lane_word_c[7:0]}
                                  : {{24{lane_word_c[7]}}, lane_word_c[7:0]};
      SZ_HALF: ext_c = unsigned_q ? {16'b0, lane_word_c[15:0]}
                                  : {{16{lane_word_c[15]}}, lane_word_c[15:0]};
      default: ext_c = mem.mem_rdata;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = mem_we_q;
    lane_d       = lane_q;
    size_d       = size_q;
    unsigned_d   = unsigned_q;
    load_data_d  = load_data_q;
    badvaddr_d   = badvaddr_q;
    mem_req_d    = 1'b0;
    load_valid_d = 1'b0;
    addr_err_d   = 1'b0;
    bus_err_d    = 1'b0;
    stall        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        stall = acc_c;
        if (acc_c) begin
          if (aligned_c) begin
            mem_addr_d  = {alu_result[31:2], 2'b00};
            mem_be_d    = be_c;
            mem_wdata_d = wdata_c;
            mem_we_d    = MemWrite;
            lane_d      = alu_result[1:0];
            size_d      = is_word_c ? SZ_WORD : (is_half_c ? SZ_HALF : SZ_BYTE);
            unsigned_d  = Arith_u;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            state_d     = ST_REQ;
          end else begin
            badvaddr_d  = alu_result;
            addr_err_d  = 1'b1;
            state_d     = ST_ERR_A;
          end
        end
      end

      ST_REQ: begin
        stall = 1'b1;
        if (mem.mem_ack) begin
          if (!mem_we_q) begin
            load_data_d  = ext_c;
            load_valid_d = 1'b1;
          end
          cnt_d   = '0;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          // Rebuild the original byte address from the latched word address.
          badvaddr_d = {mem_addr_q[31:2], lane_q};
          bus_err_d  = 1'b1;
          cnt_d      = '0;
          state_d    = ST_ERR_B;
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
          mem_req_d = 1'b1;
        end
      end

      ST_DONE, ST_ERR_A, ST_ERR_B: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      mem_req_q    <= 1'b0;
      lane_q       <= 2'b00;
      size_q       <= SZ_BYTE;
      unsigned_q   <= 1'b0;
      load_valid_q <= 1'b0;
      load_data_q  <= '0;
      addr_err_q   <= 1'b0;
      bus_err_q    <= 1'b0;
      badvaddr_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      mem_req_q    <= mem_req_d;
      lane_q       <= lane_d;
      size_q       <= size_d;
      unsigned_q   <= unsigned_d;
      load_valid_q <= load_valid_d;
      load_data_q  <= load_data_d;
      addr_err_q   <= addr_err_d;
      bus_err_q    <= bus_err_d;
      badvaddr_q   <= badvaddr_d;
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_be    = mem_be_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign load_valid    = load_valid_q;
  assign load_data     = load_data_q;
  assign addr_err      = addr_err_q;
  assign bus_err       = bus_err_q;
  assign badvaddr      = badvaddr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized instructions,
// every cycle compared against a transaction-level timeline model.
module tb_load_store_unit;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemWrite, MemtoReg, Arith_u;
  logic [3:0]  ByteControl;
  logic [31:0] alu_result, store_data;
  logic        stall, load_valid, addr_err, bus_err;
  logic [31:0] load_data, badvaddr;

  load_store_unit_if mif();

  load_store_unit #(.ACK_TIMEOUT(TO), .CNT_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .MemWrite   (MemWrite),
    .MemtoReg   (MemtoReg),
    .ByteControl(ByteControl),
    .Arith_u    (Arith_u),
    .alu_result (alu_result),
    .store_data (store_data),
    .mem        (mif.master),
    .stall      (stall),
    .load_valid (load_valid),
    .load_data  (load_data),
    .addr_err   (addr_err),
    .bus_err    (bus_err),
    .badvaddr   (badvaddr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        lv;
    logic [31:0] ld;
    logic        aerr;
    logic        berr;
    logic [31:0] bva;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_ld, m_bva;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
    end
  endtask

  // Per-cycle compare against the expected timeline.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("stall",      32'(stall),        32'(e.stall));
      check("mem_req",    32'(mif.mem_req),  32'(e.req));
      if (e.req) begin
        check("mem_we",    32'(mif.mem_we),  32'(e.we));
        check("mem_be",    32'(mif.mem_be),  32'(e.be));
        check("mem_addr",  mif.mem_addr,     e.addr);
        check("mem_wdata", mif.mem_wdata,    e.wdata);
      end
      check("load_valid", 32'(load_valid),   32'(e.lv));
      check("load_data",  load_data,         e.ld);
      check("addr_err",   32'(addr_err),     32'(e.aerr));
      check("bus_err",    32'(bus_err),      32'(e.berr));
      check("badvaddr",   badvaddr,          e.bva);
    end
  end

  // Present one instruction until it retires. k = REQ cycle carrying mem_ack
  // (1..TO), 0 = never acked. xack = mem_ack value outside REQ cycles.
  task automatic run_instr(input logic mw, input logic mtr, input logic [3:0] bc,
                           input logic u, input logic [31:0] a, input logic [31:0] sd,
                           input int k, input logic [31:0] rd, input logic xack,
                           output int sc, output int rc, output logic [3:0] obe,
                           output logic [31:0] oaddr, output logic [31:0] owdata,
                           output logic owe);
    int          sz, n;
    bit          acc, al;
    logic [31:0] mask, v, wd;
    logic [3:0]  be;
    sz   = (bc == 4'b1111) ? 4 : (bc == 4'b0011) ? 2 : (bc == 4'b0001) ? 1 : 0;
    acc  = (mw | mtr) && (sz != 0);
    al   = acc && ((a % sz) == 0);
    be   = 4'(((1 << sz) - 1) << (a % 4));
    wd   = (sz == 1) ? 32'(sd[7:0]) * 32'h0101_0101 :
           (sz == 2) ? 32'(sd[15:0]) * 32'h0001_0001 : sd;
    mask = (sz == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * sz)) - 32'd1;
    v    = (rd >> (8 * (a % 4))) & mask;
    if (!u && sz < 4 && sz > 0 && v[8*sz-1]) v = v | ~mask;
    n    = !acc ? 1 : !al ? 2 : (k == 0) ? TO + 2 : k + 2;

    for (int c = 0; c < n; c++) begin
      exp_t e;
      e.stall = acc && (c < n - 1);
      e.req   = al && c >= 1 && c <= n - 2;
      e.we    = mw;
      e.be    = be;
      e.addr  = a & 32'hFFFF_FFFC;
      e.wdata = wd;
      e.lv    = 1'b0;
      e.aerr  = 1'b0;
      e.berr  = 1'b0;
      if (acc && c == n - 1) begin
        if (!al)          begin m_bva = a; e.aerr = 1'b1; end
        else if (k == 0)  begin m_bva = a; e.berr = 1'b1; end
        else if (!mw)     begin m_ld  = v; e.lv   = 1'b1; end
      end
      e.ld  = m_ld;
      e.bva = m_bva;
      exp_q.push_back(e);
    end

    MemWrite = mw; MemtoReg = mtr; ByteControl = bc; Arith_u = u;
    alu_result = a; store_data = sd; mif.mem_rdata = rd;
    sc = 0; rc = 0; obe = '0; oaddr = '0; owdata = '0; owe = 1'b0;
    for (int c = 0; c < n; c++) begin
      if (al && c >= 1 && c <= n - 2) mif.mem_ack = (k != 0 && c == k);
      else                            mif.mem_ack = xack;
      @(negedge clk);
      if (stall) sc++;
      if (mif.mem_req) begin
        rc++; obe = mif.mem_be; oaddr = mif.mem_addr; owdata = mif.mem_wdata; owe = mif.mem_we;
      end
      @(posedge clk); #1;
    end
    MemWrite = 1'b0; MemtoReg = 1'b0; ByteControl = 4'b0000; mif.mem_ack = 1'b0;
  endtask

  initial begin
    int          sc, rc, k, r;
    logic [3:0]  obe, bc;
    logic [31:0] oaddr, owd;
    logic        owe;

    rst = 1'b1;
    MemWrite = 0; MemtoReg = 0; ByteControl = 0; Arith_u = 0;
    alu_result = 0; store_data = 0; mif.mem_ack = 0; mif.mem_rdata = 0;
    m_ld = 0; m_bva = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req",    32'(mif.mem_req),  0);
    check("rst_mem_we",     32'(mif.mem_we),   0);
    check("rst_mem_be",     32'(mif.mem_be),   0);
    check("rst_mem_addr",   mif.mem_addr,      0);
    check("rst_mem_wdata",  mif.mem_wdata,     0);
    check("rst_load_valid", 32'(load_valid),   0);
    check("rst_load_data",  load_data,         0);
    check("rst_addr_err",   32'(addr_err),     0);
    check("rst_bus_err",    32'(bus_err),      0);
    check("rst_badvaddr",   badvaddr,          0);
    check("rst_stall",      32'(stall),        0);
    rst = 1'b0;

    // lb signed / unsigned from lane 2
    run_instr(0, 1, 4'b0001, 0, 32'h1002, 0, 1, 32'h80C3_7F01, 1'b0, sc, rc, obe, oaddr, owd, owe);
    check("lb_stall_cycles", 32'(sc), 2);
    check("lb_be",           32'(obe), 32'b0100);
    check("lb_addr",         oaddr, 32'h1000);
    check("lb_data",         load_data, 32'hFFFF_FFC3);
    run_instr(0, 1, 4'b0001, 1, 32'h1002, 0, 1, 32'h80C3_7F01, 1'b1, sc, rc, obe, oaddr, owd, owe);
    check("lbu_stall_cycles", 32'(sc), 2);
    check("lbu_data",         load_data, 32'h0000_00C3);

    // sh: replicated data, upper lanes, load_data untouched
    run_instr(1, 0, 4'b0011, 0, 32'h2006, 32'h1234_ABCD, 1, 32'hDEAD_BEEF, 1'b0, sc, rc, obe, oaddr, owd, owe);
    check("sh_we",    32'(owe), 1);
    check("sh_be",    32'(obe), 32'b1100);
    check("sh_wdata", owd, 32'hABCD_ABCD);
    check("sh_addr",  oaddr, 32'h2004);
    check("sh_ld_held", load_data, 32'h0000_00C3);

    // misaligned word / half, aligned byte at the same odd address
    run_instr(0, 1, 4'b1111, 0, 32'h3001, 0, 1, 0, 1'b0, sc, rc, obe, oaddr, owd, owe);
    check("lw_mis_req_cycles", 32'(rc), 0);
    check("lw_mis_badvaddr",   badvaddr, 32'h3001);
    run_instr(0, 1, 4'b0011, 0, 32'h3003, 0, 1, 0, 1'b0, sc, rc, obe, oaddr, owd, owe);
    check("lh_mis_req_cycles", 32'(rc), 0);
    check("lh_mis_badvaddr",   badvaddr, 32'h3003);
    run_instr(0, 1, 4'b0001, 0, 32'h3003, 0, 1, 32'h7F00_0000, 1'b0, sc, rc, obe, oaddr, owd, owe);
    check("lb_odd_req_cycles", 32'(rc), 1);
    check("lb_odd_be",         32'(obe), 32'b1000);
    check("lb_odd_data",       load_data, 32'h0000_007F);

    // timeout, then late acks while idle
    run_instr(0, 1, 4'b1111, 0, 32'h4000, 0, 0, 0, 1'b0, sc, rc, obe, oaddr, owd, owe);
    check("to_req_cycles",   32'(rc), TO);
    check("to_stall_cycles", 32'(sc), TO + 1);
    check("to_badvaddr",     badvaddr, 32'h4000);
    run_instr(0, 1, 4'b0000, 0, 32'h4000, 0, 1, 0, 1'b1, sc, rc, obe, oaddr, owd, owe);
    run_instr(0, 0, 4'b1111, 0, 32'h4000, 0, 1, 0, 1'b1, sc, rc, obe, oaddr, owd, owe);
    check("late_ack_req_cycles", 32'(rc), 0);

    // wait states, then back-to-back store
    run_instr(0, 1, 4'b1111, 0, 32'h5008, 0, 3, 32'hCAFE_F00D, 1'b0, sc, rc, obe, oaddr, owd, owe);
    check("ws_stall_cycles", 32'(sc), 4);
    check("ws_data",         load_data, 32'hCAFE_F00D);
    run_instr(1, 0, 4'b1111, 0, 32'h500C, 32'h0BAD_CAFE, 1, 0, 1'b0, sc, rc, obe, oaddr, owd, owe);
    check("b2b_sw_req_cycles", 32'(rc), 1);
    check("b2b_sw_wdata",      owd, 32'h0BAD_CAFE);

    // reset in the second REQ cycle
    MemtoReg = 1; ByteControl = 4'b1111; Arith_u = 0; alu_result = 32'h6000; mif.mem_ack = 0;
    @(posedge clk); #1;
    check("mid_rst_req1", 32'(mif.mem_req), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_req_drop", 32'(mif.mem_req), 0);
    check("mid_rst_lv",       32'(load_valid), 0);
    MemtoReg = 0; ByteControl = 4'b0000;
    @(posedge clk); #1;
    rst = 1'b0;
    m_ld = 0; m_bva = 0;
    run_instr(0, 0, 4'b0000, 0, 0, 0, 1, 32'h1111_1111, 1'b1, sc, rc, obe, oaddr, owd, owe);
    check("post_rst_lv", 32'(load_valid), 0);

    // ByteControl 0000 is no access
    run_instr(0, 1, 4'b0000, 0, 32'h7000, 0, 1, 0, 1'b0, sc, rc, obe, oaddr, owd, owe);
    check("none_stall_cycles", 32'(sc), 0);
    check("none_req_cycles",   32'(rc), 0);

    // randomized instructions
    for (int i = 0; i < 250; i++) begin
      r  = int'($urandom_range(0, 9));
      bc = (r < 3) ? 4'b1111 : (r < 6) ? 4'b0011 : (r < 8) ? 4'b0001 :
           (r == 8) ? 4'b0000 : 4'($urandom);
      k  = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 4));
      run_instr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), bc,
                1'($urandom_range(0, 1)), $urandom, $urandom, k, $urandom,
                1'($urandom_range(0, 1)), sc, rc, obe, oaddr, owd, owe);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
